fp_mul_sequencer: RTL and testbench
===================================

FP_MUL_SEQUENCER -- requirements
Module: fp_mul_sequencer

Interface
REQ-001 SHALL have parameter EXP_SIZE, default `EXP_SIZE, giving the exponent width.
REQ-002 SHALL have parameter MANTIS_SIZE, default `MANTIS_SIZE, giving the mantissa width.
REQ-003 SHALL use W = 1+EXP_SIZE+MANTIS_SIZE throughout, with operand layout {sign, exp, mantis}.
REQ-004 SHALL have clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have in_valid  input  1  upstream operand pair valid.
REQ-007 SHALL have in_ready  output  1  sequencer can accept an operand pair.
REQ-008 SHALL have in_a, in_b  input  W each  operands to multiply.
REQ-009 SHALL have core_start  output  1  one-cycle start pulse to the shared multiplier core.
REQ-010 SHALL have core_a, core_b  output  W each  operands to the core; held stable from start until done.
REQ-011 SHALL have core_done  input  1  one-cycle completion pulse from the core.
REQ-012 SHALL have core_result  input  W  core product; valid when core_done=1.
REQ-013 SHALL have out_valid  output  1  result valid.
REQ-014 SHALL have out_ready  input  1  downstream accepts the result.
REQ-015 SHALL have out_result  output  W  product.
REQ-016 SHALL have out_special  output  1  result came from the special-case bypass, not from the core.

Function
REQ-017 SHALL classify each operand with the team's 3-bit type code: ZERO=000, INF=001, SUBNORMAL=010, NORMAL=011, NAN=100 (exp==0: ZERO if mantis==0, else SUBNORMAL; exp all-ones: INF if mantis==0, else NAN; otherwise NORMAL).
REQ-018 SHALL implement FSM states IDLE, CLASSIFY, WAIT_CORE and OUTPUT.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch in_a/in_b and go to CLASSIFY; no other state asserts in_ready.
REQ-020 CLASSIFY (exactly 1 cycle): classify the latched operands and apply REQ-021..REQ-024 in priority order.
REQ-021 If either operand is NAN, or one is INF and the other ZERO, SHALL produce qNaN = {0, all-ones exp, 1, zeros} with out_special=1 and go to OUTPUT.
REQ-022 Else if either operand is INF, SHALL produce {sa^sb, all-ones exp, zero mantis} with out_special=1 and go to OUTPUT.
REQ-023 Else if either operand is ZERO, SHALL produce {sa^sb, zeros} with out_special=1 and go to OUTPUT.
REQ-024 Otherwise SHALL assert core_start for that single cycle and go to WAIT_CORE.
REQ-025 WAIT_CORE: on core_done, register core_result with out_special=0 and go to OUTPUT; core_done outside WAIT_CORE SHALL be ignored.
REQ-026 OUTPUT: out_valid=1 with out_result and out_special held stable until out_ready=1, then go to IDLE in the next cycle.
REQ-027 Latency for the bypass path: accept in cycle T, out_valid in cycle T+2.
REQ-028 Latency for the core path: core_start in T+1; core_done in cycle D gives out_valid in D+1.
REQ-029 SHALL start at most one core operation at a time; core_start SHALL never reassert before core_done is received.
REQ-030 A core_done arriving in the same cycle as core_start SHALL be ignored, because the FSM enters WAIT_CORE only after the start cycle.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-operation, SHALL immediately force the FSM to IDLE.
REQ-032 Reset SHALL set out_valid=0, core_start=0, out_special=0, out_result=0, core_a=0 and core_b=0.
REQ-033 in_ready SHALL be 1 while in reset.
REQ-034 A core operation in flight at reset SHALL be abandoned, and its later core_done SHALL be ignored.

Configuration
REQ-035 Macro FP_SUBNORM_FLUSH_EN defined: SUBNORMAL operands SHALL be treated as ZERO (sign kept) in REQ-021..REQ-023.
REQ-036 Macro FP_SUBNORM_FLUSH_EN absent: SUBNORMAL operands SHALL be treated as NORMAL and sent to the core.

Verification
REQ-037 Parameters 8/23 (EXP_SIZE/MANTIS_SIZE): a=0x7FC00001, b=0x3F800000 -> out_result=0x7FC00000, out_special=1, out_valid at T+2, core_start never asserted.
REQ-038 a=0xFF800000 (-Inf), b=0x00000000 -> 0x7FC00000; a=0xFF800000, b=0x40000000 -> 0xFF800000; all with out_special=1.
REQ-039 a=0x3F800000, b=0x40000000; core returns 0x40000000 three cycles after start -> core_start pulses once at T+1, out_result=0x40000000, out_special=0.
REQ-040 Hold out_ready=0 for 5 cycles in OUTPUT -> out_result stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-041 a=0x00000001, b=0x3F800000 -> with FP_SUBNORM_FLUSH_EN: 0x00000000, out_special=1; without it: core_start asserted.
REQ-042 Assert rst_n=0 during WAIT_CORE, release it, then pulse core_done -> out_valid stays 0, in_ready=1, next operation proceeds normally.

Source files
------------

// File: rtl/fp_mul_sequencer.sv
// fp_mul_sequencer: front-end for a shared floating-point multiplier core.
// Operand pairs are classified. Special cases (NaN, Inf, zero) are answered
// directly. All other pairs go to the core through a start/done handshake.
// Operand layout is {sign, exp, mantis}; W = 1 + EXP_SIZE + MANTIS_SIZE.
// Optional build macro: FP_SUBNORM_FLUSH_EN. When defined, subnormal operands
// are treated as signed zeros. When absent, they are sent to the core.

`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

module fp_mul_sequencer #(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] in_a,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] in_b,
  output logic                          core_start,
  output logic [EXP_SIZE+MANTIS_SIZE:0] core_a,
  output logic [EXP_SIZE+MANTIS_SIZE:0] core_b,
  input  logic                          core_done,
  input  logic [EXP_SIZE+MANTIS_SIZE:0] core_result,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_SIZE+MANTIS_SIZE:0] out_result,
  output logic                          out_special
);

  localparam int W = 1 + EXP_SIZE + MANTIS_SIZE;

  typedef enum logic [2:0] {
    FT_ZERO = 3'b000,
    FT_INF  = 3'b001,
    FT_SUB  = 3'b010,
    FT_NORM = 3'b011,
    FT_NAN  = 3'b100
  } ftype_t;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    WAIT_CORE,
    OUTPUT
  } state_t;

  function automatic ftype_t classify(input logic [W-1:0] v);
    logic [EXP_SIZE-1:0]    e;
    logic [MANTIS_SIZE-1:0] m;
    e = v[W-2:MANTIS_SIZE];
    m = v[MANTIS_SIZE-1:0];
    if (e == '0)      return (m == '0) ? FT_ZERO : FT_SUB;
    else if (e == '1) return (m == '0) ? FT_INF  : FT_NAN;
    else              return FT_NORM;
  endfunction

  state_t         state;
  ftype_t         ta, tb;
  logic           sgn;
  logic           byp_hit;
  logic [W-1:0]   byp_val;
  logic           byp_hit_q;
  logic [W-1:0]   byp_val_q;

  // Bypass decision computed from the operands as they are captured. The
  // result is registered with them, so core_start can be a registered pulse
  // during the CLASSIFY cycle.
  always_comb begin
    ta      = classify(in_a);
    tb      = classify(in_b);
`ifdef FP_SUBNORM_FLUSH_EN
    if (ta == FT_SUB) ta = FT_ZERO;
    if (tb == FT_SUB) tb = FT_ZERO;
`else
    if (ta == FT_SUB) ta = FT_NORM;
    if (tb == FT_SUB) tb = FT_NORM;
`endif
    sgn     = in_a[W-1] ^ in_b[W-1];
    byp_hit = 1'b1;
    byp_val = '0;
    if (ta == FT_NAN || tb == FT_NAN ||
        (ta == FT_INF && tb == FT_ZERO) || (ta == FT_ZERO && tb == FT_INF)) begin
      byp_val = {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(MANTIS_SIZE-1){1'b0}}};
    end else if (ta == FT_INF || tb == FT_INF) begin
      byp_val = {sgn, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};
    end else if (ta == FT_ZERO || tb == FT_ZERO) begin
      byp_val = {sgn, {(W-1){1'b0}}};
    end else begin
      byp_hit = 1'b0;
    end
  end

  // Sequencer FSM with registered handshake and datapath outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      core_start  <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_special <= 1'b0;
      byp_hit_q   <= 1'b0;
      byp_val_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            core_a     <= in_a;
            core_b     <= in_b;
            byp_hit_q  <= byp_hit;
            byp_val_q  <= byp_val;
            core_start <= ~byp_hit;
            in_ready   <= 1'b0;
            state      <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          core_start <= 1'b0;
          if (byp_hit_q) begin
            out_result  <= byp_val_q;
            out_special <= 1'b1;
            out_valid   <= 1'b1;
            state       <= OUTPUT;
          end else begin
            state <= WAIT_CORE;
          end
        end
        WAIT_CORE: begin
          if (core_done) begin
            out_result  <= core_result;
            out_special <= 1'b0;
            out_valid   <= 1'b1;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready   <= 1'b1;
          core_start <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Self-checking bench for fp_mul_sequencer with 8/23 (binary32) operands.
// The bench models the multiplier core and uses a scoreboard queue of
// expected results.
module tb_fp_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        core_start;
  logic [31:0] core_a, core_b;
  logic        core_done;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_special;

  fp_mul_sequencer #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_special(out_special)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Core model: counts starts and answers core_lat cycles after each start.
  int          core_lat = 3;
  logic [31:0] core_res_nxt = '0;
  bit          early_done = 0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          pend = 0;

  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_done   = 1'b1;
          core_result = core_res_nxt;
        end
      end
      if (core_start) begin
        start_cnt++;
        start_cyc = cyc;
        pend      = core_lat;
        if (early_done) begin
          core_done   = 1'b1;
          core_result = ~core_res_nxt;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] a, b, er;
    logic        es;
    logic [31:0] cr;
    int          lat;
    int          hold;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        spec;
  } exp_t;

  exp_t exp_q[$];

  task automatic do_op(input vec_t v);
    int   t_acc, n0;
    bit   got;
    exp_t e;
    core_lat     = v.lat;
    core_res_nxt = v.cr;
    n0           = start_cnt;
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_valid = 1'b1;
    check({v.nm, " in_ready"}, {31'd0, in_ready}, 32'd1);
    t_acc = cyc;
    exp_q.push_back('{res: v.er, spec: v.es});
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) begin
      check({v.nm, " out_valid timeout"}, 32'd0, 32'd1);
      return;
    end
    if (v.es) begin
      check({v.nm, " latency"}, cyc, t_acc + 2);
      check({v.nm, " no core_start"}, start_cnt, n0);
    end else begin
      check({v.nm, " start count"}, start_cnt, n0 + 1);
      check({v.nm, " start cycle"}, start_cyc, t_acc + 1);
      check({v.nm, " latency"}, cyc, start_cyc + v.lat + 1);
    end
    if (exp_q.size() == 0) begin
      check({v.nm, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({v.nm, " result"}, out_result, e.res);
      check({v.nm, " special"}, {31'd0, out_special}, {31'd0, e.spec});
    end
    // Stall the output; a competing operand must not be accepted.
    for (int h = 0; h < v.hold; h++) begin
      in_a = 32'hDEADBEEF; in_b = 32'h3F800000; in_valid = 1'b1;
      @(negedge clk);
      check({v.nm, " hold result"}, out_result, v.er);
      check({v.nm, " hold valid"}, {31'd0, out_valid}, 32'd1);
      check({v.nm, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
      check({v.nm, " hold core_a"}, core_a, v.a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.nm, " idle valid"}, {31'd0, out_valid}, 32'd0);
    check({v.nm, " idle in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, 32'h0, 3, 0, "nan_x_one"});
    vecs.push_back('{32'hFF800000, 32'h00000000, 32'h7FC00000, 1'b1, 32'h0, 3, 0, "ninf_x_zero"});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1, 32'h0, 3, 0, "ninf_x_two"});
    vecs.push_back('{32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 32'h40000000, 3, 5, "one_x_two"});
    vecs.push_back('{32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 32'h0, 3, 0, "nzero_x_one"});
    vecs.push_back('{32'h00000000, 32'h7F800000, 32'h7FC00000, 1'b1, 32'h0, 3, 0, "zero_x_inf"});
    vecs.push_back('{32'hC0400000, 32'h7F800000, 32'hFF800000, 1'b1, 32'h0, 3, 2, "neg_x_inf"});
    vecs.push_back('{32'h7F800001, 32'h00000000, 32'h7FC00000, 1'b1, 32'h0, 3, 0, "snan_x_zero"});
    vecs.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 32'hC0C00000, 1, 0, "core_lat1"});
`ifdef FP_SUBNORM_FLUSH_EN
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, 1'b1, 32'h0, 2, 0, "sub_x_one"});
    vecs.push_back('{32'h80000001, 32'h3F800000, 32'h80000000, 1'b1, 32'h0, 2, 0, "nsub_x_one"});
    vecs.push_back('{32'hFF800000, 32'h80000001, 32'h7FC00000, 1'b1, 32'h0, 2, 0, "ninf_x_nsub"});
`else
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h12345678, 1'b0, 32'h12345678, 2, 0, "sub_x_one"});
    vecs.push_back('{32'h80000001, 32'h3F800000, 32'h87654321, 1'b0, 32'h87654321, 4, 0, "nsub_x_one"});
    vecs.push_back('{32'hFF800000, 32'h80000001, 32'h7F800000, 1'b1, 32'h0, 2, 0, "ninf_x_nsub"});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset core_start", {31'd0, core_start}, 32'd0);
    check("reset out_special", {31'd0, out_special}, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset core_a", core_a, 32'd0);
    check("reset core_b", core_b, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i]);

    // A done pulse in the start cycle must be ignored; only the later one counts.
    early_done = 1;
    do_op('{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 32'h40400000, 3, 0, "early_done"});
    early_done = 0;

    // Reset while waiting on the core; the stale done must be ignored.
    core_lat = 6; core_res_nxt = 32'h40000000;
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("midop core_start", {31'd0, core_start}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst core_a", core_a, 32'd0);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("post_rst out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst in_ready", {31'd0, in_ready}, 32'd1);
    end
    do_op('{32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 32'h40800000, 2, 0, "after_rst"});
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
